param_updown_mod_counter: RTL and testbench

//   Parametrised, loadable, up/down modulo-N counter built from per-bit toggle (T) cells.

---
 rtl/param_updown_mod_counter_if.sv | 12 +
 rtl/param_updown_mod_counter.sv | 36 +++
 tb/tb_param_updown_mod_counter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/param_updown_mod_counter_if.sv
// param_updown_mod_counter_if: control/status bundle between a counter user (master) and the counter (slave)
interface param_updown_mod_counter_if #(parameter int WIDTH = 4);
    logic en;
    logic load;
    logic up_dn;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic tc;
    logic wrap;
    modport master(output en, load, up_dn, d, input q, tc, wrap);
    modport slave(input en, load, up_dn, d, output q, tc, wrap);
endinterface

// File: rtl/param_updown_mod_counter.sv
// param_updown_mod_counter: loadable up/down modulo-MODULUS counter of per-bit T cells; COUNTER_SATURATE_EN makes it saturate instead of wrap
module param_updown_mod_counter #(
    parameter int WIDTH = 4,
    parameter int MODULUS = 10
) (
    input logic clk,
    input logic rst,
    param_updown_mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] d_cl;
    logic tc;
    assign d_cl = (32'(bus.d) < MODULUS) ? bus.d : MAX;
    assign tc = bus.en & ~bus.load & (bus.up_dn ? (q == MAX) : (q == '0));
`ifdef COUNTER_SATURATE_EN
    always_comb q_next = (~bus.en | tc) ? q : bus.up_dn ? q + 1'b1 : q - 1'b1;
    assign bus.wrap = 1'b0;
`else
    logic wrap;
    always_comb q_next = ~bus.en ? q : tc ? (bus.up_dn ? '0 : MAX) : bus.up_dn ? q + 1'b1 : q - 1'b1;
    always_ff @(posedge clk) wrap <= rst ? 1'b0 : tc;
    assign bus.wrap = wrap;
`endif
    assign t = q ^ q_next;
    for (genvar i = 0; i < WIDTH; i++) begin : g_tcell
        always_ff @(posedge clk)
            if (rst) q[i] <= 1'b0;
            else if (bus.load) q[i] <= d_cl[i];
            else if (t[i]) q[i] <= ~q[i];
    end
    assign bus.q = q;
    assign bus.tc = tc;
endmodule

// File: tb/tb_param_updown_mod_counter.sv
// tb_param_updown_mod_counter: directed table, MODULUS=16 full cycle and randomized model check of the counter
module tb_param_updown_mod_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    param_updown_mod_counter_if #(.WIDTH(4)) a ();
    param_updown_mod_counter_if #(.WIDTH(4)) b ();
    param_updown_mod_counter #(.WIDTH(4), .MODULUS(10)) u0 (.clk(clk), .rst(rst), .bus(a.slave));
    param_updown_mod_counter #(.WIDTH(4), .MODULUS(16)) u1 (.clk(clk), .rst(rst), .bus(b.slave));
    typedef struct {
        bit r, l, e, u;
        int d, tc, q, w;
    } vec_t;
    vec_t tab[$];
    int checks = 0;
    int errors = 0;
    int mq, mq2, wraps;
    function automatic void add(bit r, bit l, bit e, bit u, int d, int tc, int q, int w);
        vec_t v;
        v = '{r, l, e, u, d, tc, q, w};
        tab.push_back(v);
    endfunction
    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask
    function automatic int m_tc(int q, int m, bit e, bit l, bit u);
        return int'(e && !l && (u ? q == m - 1 : q == 0));
    endfunction
    function automatic int m_next(int q, int m, bit r, bit l, bit e, bit u, int d);
        if (r) return 0;
        if (l) return d < m ? d : m - 1;
        if (!e) return q;
`ifdef COUNTER_SATURATE_EN
        if (m_tc(q, m, e, l, u) != 0) return q;
`endif
        return u ? (q + 1) % m : (q + m - 1) % m;
    endfunction
    function automatic int m_wrap(int q, int m, bit r, bit l, bit e, bit u);
`ifdef COUNTER_SATURATE_EN
        return 0;
`else
        return r ? 0 : m_tc(q, m, e, l, u);
`endif
    endfunction
    task automatic drive(bit r, bit l, bit e, bit u, int d);
        rst = r;
        a.load = l;
        a.en = e;
        a.up_dn = u;
        a.d = 4'(d);
    endtask
    initial begin
        drive(0, 0, 0, 0, 0);
        b.load = 0; b.en = 0; b.up_dn = 0; b.d = '0;
        add(1, 1, 1, 1, 7, 0, 0, 0);
        add(1, 1, 1, 1, 7, 0, 0, 0);
`ifndef COUNTER_SATURATE_EN
        add(0, 1, 0, 1, 8, 0, 8, 0);
        add(0, 0, 1, 1, 0, 0, 9, 0);
        add(0, 0, 1, 1, 0, 1, 0, 1);
        add(0, 0, 1, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 9, 1);
        add(0, 0, 1, 0, 0, 0, 8, 0);
`else
        add(0, 1, 0, 1, 9, 0, 9, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 0, 1, 9, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0, 0);
`endif
        add(0, 1, 1, 1, 13, 0, 9, 0);
        add(1, 1, 0, 1, 4, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 5, 0, 5, 0);
        add(0, 0, 1, 1, 0, 0, 6, 0);
        add(0, 0, 1, 1, 0, 0, 7, 0);
        add(0, 0, 1, 0, 0, 0, 6, 0);
        add(0, 0, 1, 0, 0, 0, 5, 0);
        add(0, 0, 1, 0, 0, 0, 4, 0);
        foreach (tab[i]) begin
            drive(tab[i].r, tab[i].l, tab[i].e, tab[i].u, tab[i].d);
            #1 chk($sformatf("tab%0d_tc", i), 32'(a.tc), 32'(tab[i].tc));
            @(posedge clk);
            #1 chk($sformatf("tab%0d_q", i), 32'(a.q), 32'(tab[i].q));
            chk($sformatf("tab%0d_wrap", i), 32'(a.wrap), 32'(tab[i].w));
        end
        mq = 4;
        drive(0, 0, 0, 0, 0);
        mq2 = 0;
        wraps = 0;
        b.load = 1; b.d = 4'd0;
        @(posedge clk);
        #1 chk("m16_load", 32'(b.q), 32'(mq2));
        b.load = 0; b.en = 1; b.up_dn = 1;
        for (int i = 0; i < 16; i++) begin
            #1 chk("m16_tc", 32'(b.tc), 32'(m_tc(mq2, 16, 1, 0, 1)));
            @(posedge clk);
            #1 chk("m16_wrap", 32'(b.wrap), 32'(m_wrap(mq2, 16, 0, 0, 1, 1)));
            mq2 = m_next(mq2, 16, 0, 0, 1, 1, 0);
            chk("m16_q", 32'(b.q), 32'(mq2));
            wraps += int'(b.wrap);
        end
`ifndef COUNTER_SATURATE_EN
        chk("m16_wrap_count", 32'(wraps), 32'd1);
        chk("m16_final_q", 32'(b.q), 32'd0);
`else
        chk("m16_wrap_count", 32'(wraps), 32'd0);
        chk("m16_final_q", 32'(b.q), 32'd15);
`endif
        b.en = 0;
        for (int i = 0; i < 500; i++) begin
            bit r, l, e, u;
            int d;
            r = ($urandom_range(31) == 0);
            l = ($urandom_range(7) == 0);
            e = ($urandom_range(3) != 0);
            u = 1'($urandom_range(1));
            d = int'($urandom_range(15));
            drive(r, l, e, u, d);
            #1 chk("rnd_tc", 32'(a.tc), 32'(m_tc(mq, 10, e, l, u)));
            @(posedge clk);
            #1 chk("rnd_wrap", 32'(a.wrap), 32'(m_wrap(mq, 10, r, l, e, u)));
            mq = m_next(mq, 10, r, l, e, u, d);
            chk("rnd_q", 32'(a.q), 32'(mq));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
